// File: rtl/sd_hc_pkg.sv
// sd_hc_pkg: SD host controller register offsets, Clock Control bits, clock FSM states
package sd_hc_pkg;
  localparam logic [11:0] REG_CAP = 12'h040;
  localparam logic [11:0] REG_CLK_CTRL = 12'h02C;
  localparam int ICE_BIT = 0;
  localparam int ICS_BIT = 1;
  localparam int SDCE_BIT = 2;
  typedef enum logic [3:0] {
    IDLE, STOP, RD_CAP, CALC, SET_DIV, POLL, ON, DONE, ERR
  } clk_state_t;
  function automatic logic [31:0] ctrl_word(logic [9:0] n, logic sdce);
    return {16'h0, n[7:0], n[9:8], 3'b0, sdce, 1'b0, 1'b1};
  endfunction
endpackage

// File: rtl/sd_clk_ctrl_if.sv
// sd_clk_ctrl_if: register memory-map port (read index/data, write strobe/index/data/attr)
interface sd_clk_ctrl_if;
  logic [11:0] rd_reg_index;
  logic [127:0] rd_reg_input;
  logic wr_reg_strb;
  logic [11:0] wr_reg_index;
  logic [31:0] wr_reg_output;
  logic [2:0] reg_attr;
  modport master(output rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr, input rd_reg_input);
  modport slave(input rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr, output rd_reg_input);
endinterface

// File: rtl/sd_clk_div_calc.sv
// sd_clk_div_calc: iterative smallest N with 2*N*req >= base (start pulse in, done pulse + n out)
module sd_clk_div_calc #(
  parameter int DIV_W = 10
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic [23:0] req,
  input logic [17:0] base,
  output logic done,
  output logic [DIV_W-1:0] n
);
  localparam logic [DIV_W-1:0] N_MAX = '1;
  logic busy;
  logic [33:0] acc;
  logic [33:0] step;
  logic trivial;
  assign step = {9'b0, req, 1'b0};
  assign trivial = req == 24'd0 || req >= {6'b0, base};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      acc <= '0;
      n <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        n <= req == 24'd0 ? N_MAX : req >= {6'b0, base} ? '0 : DIV_W'(1);
        done <= trivial;
        busy <= !trivial;
        acc <= step;
      end else if (busy) begin
        if (acc >= {16'b0, base} || n == N_MAX) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          acc <= acc + step;
          n <= n + DIV_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/sd_clk_ctrl.sv
// sd_clk_ctrl: programs SDCLK divisor/enable via Clock Control register; ports: strobes, req_clk, reg bus, status
module sd_clk_ctrl
  import sd_hc_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int STABLE_TOUT = 1024,
  parameter int BCF_DFLT_MHZ = 50,
  parameter int DIV_W = 10
) (
  input logic clk,
  input logic reset,
  input logic calc_clk_strb,
  input logic clk_stop_strb,
  input logic [23:0] req_clk,
  sd_clk_ctrl_if.master bus,
  output logic sd_clk_enb_strb,
  output logic sd_clk_proc,
  output logic sd_clk_err,
  output logic [DIV_W-1:0] sd_clk_div,
  output logic sd_clk_on
);
  clk_state_t state, nxt;
  logic is_calc;
  logic [23:0] req;
  logic [7:0] bcf;
  logic [3:0] lat_cnt;
  logic [15:0] tout_cnt;
  logic lat_hit, stable, timeout, calc_done, wr;
  logic [17:0] base_khz;
  logic [DIV_W-1:0] n_calc;
  assign lat_hit = lat_cnt == 4'(RD_LAT);
  assign stable = lat_hit && bus.rd_reg_input[ICS_BIT];
  assign timeout = tout_cnt == 16'(STABLE_TOUT - 1);
  assign base_khz = 18'(bcf) * 18'd1000;
  sd_clk_div_calc #(.DIV_W(DIV_W)) u_calc (
    .clk(clk),
    .reset(reset),
    .start(state == CALC && tout_cnt == 16'd0),
    .req(req),
    .base(base_khz),
    .done(calc_done),
    .n(n_calc)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = calc_clk_strb ? (sd_clk_on ? STOP : RD_CAP) : clk_stop_strb ? (sd_clk_on ? STOP : DONE) : IDLE;
      STOP: nxt = is_calc ? RD_CAP : DONE;
      RD_CAP: nxt = lat_hit ? CALC : RD_CAP;
      CALC: nxt = calc_done ? SET_DIV : CALC;
      SET_DIV: nxt = POLL;
      POLL: nxt = stable ? ON : timeout ? ERR : POLL;
      ON, ERR: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    wr = state inside {STOP, SET_DIV, ON, ERR};
    bus.wr_reg_strb = wr;
    bus.wr_reg_index = wr ? REG_CLK_CTRL : 12'h0;
    bus.wr_reg_output = state == STOP ? ctrl_word(10'(sd_clk_div), 1'b0) :
                        state == SET_DIV ? ctrl_word(10'(n_calc), 1'b0) :
                        state == ON ? ctrl_word(10'(sd_clk_div), 1'b1) : 32'h0;
    bus.rd_reg_index = state == RD_CAP ? REG_CAP : state == POLL ? REG_CLK_CTRL : 12'h0;
    bus.reg_attr = 3'b0;
    sd_clk_enb_strb = state == ON;
    sd_clk_proc = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
      tout_cnt <= '0;
      is_calc <= 1'b0;
      req <= '0;
      bcf <= '0;
      sd_clk_err <= 1'b0;
      sd_clk_on <= 1'b0;
      sd_clk_div <= '0;
    end else begin
      lat_cnt <= nxt != state ? 4'd0 : lat_hit ? 4'd1 : lat_cnt + 4'd1;
      tout_cnt <= nxt != state ? 16'd0 : tout_cnt + 16'd1;
      if (state == IDLE && calc_clk_strb) begin
        req <= req_clk;
        is_calc <= 1'b1;
        sd_clk_err <= 1'b0;
      end else if (state == IDLE && clk_stop_strb) is_calc <= 1'b0;
      if (state == RD_CAP && lat_hit)
        bcf <= bus.rd_reg_input[15:8] == 8'd0 ? 8'(BCF_DFLT_MHZ) : bus.rd_reg_input[15:8];
      if (state == STOP) sd_clk_on <= 1'b0;
      if (state == ON) sd_clk_on <= 1'b1;
      if (state == SET_DIV) sd_clk_div <= n_calc;
      if (state == ERR) sd_clk_err <= 1'b1;
    end
  end
endmodule
